rr_arbiter16: RTL and testbench

Round-robin arbiter that shares one 16-way resource among 16 requesters. It picks one requester at a time, holds the grant until release, and drives a registered 4-bit grant index plus the matching one-hot grant vector. The one-hot vector is produced by a 4-to-16 decode of the index. The arbiter sits in front of any 16-slot resource that is addressed through a 4-to-16 decoder.

---
 rtl/rr_arb_pkg.sv | 12 +
 rtl/gnt_decode4to16.sv | 20 ++
 rtl/rr_arbiter16.sv | 134 +++++++++++++
 tb/tb_rr_arbiter16.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/rr_arb_pkg.sv
// Shared types and constants for the 16-way round-robin arbiter.
package rr_arb_pkg;

  localparam int NUM_REQ = 16;
  localparam int IDX_W   = 4;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

endpackage : rr_arb_pkg

// File: rtl/gnt_decode4to16.sv
// Combinational 4-to-16 one-hot decoder with enable; all zeros when disabled.
module gnt_decode4to16
  import rr_arb_pkg::*;
(
  input  logic [IDX_W-1:0]   idx_i,
  input  logic               en_i,
  output logic [NUM_REQ-1:0] onehot_o
);

  // Drive the single bit selected by idx_i when enabled.
  always_comb begin
    onehot_o = {NUM_REQ{1'b0}};
    if (en_i) begin
      onehot_o[idx_i] = 1'b1;
    end else begin
      onehot_o = {NUM_REQ{1'b0}};
    end
  end

endmodule : gnt_decode4to16

// File: rtl/rr_arbiter16.sv
// Round-robin arbiter for 16 requesters with hold-until-release grants,
// optional hold-time limit and fully registered outputs.
module rr_arbiter16
  import rr_arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 16,
  parameter int unsigned HOLD_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               done,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               gnt_valid,
  output logic               timeout
);

  // Hold limit: the grant ends after the cycle whose counter equals HOLD_LAST.
  localparam bit                HOLD_EN   = (MAX_HOLD != 32'd0);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((MAX_HOLD == 32'd0) ? 32'd0 : (MAX_HOLD - 32'd1));

  arb_state_e         state_q,   state_d;
  logic [IDX_W-1:0]   ptr_q,     ptr_d;
  logic [IDX_W-1:0]   idx_q,     idx_d;
  logic               valid_q,   valid_d;
  logic               timeout_q, timeout_d;
  logic [HOLD_W-1:0]  hold_q,    hold_d;
  logic [NUM_REQ-1:0] gnt_q,     gnt_d;

  logic               found_s;
  logic [IDX_W-1:0]   winner_s;
  logic [IDX_W-1:0]   cand_s;
  logic               drop_s;
  logic               early_s;
  logic               hold_hit_s;
  logic               release_s;

  // Priority scan starting just after the last grantee; ptr itself is tried last.
  always_comb begin
    found_s  = 1'b0;
    winner_s = ptr_q;
    cand_s   = ptr_q;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand_s = ptr_q + IDX_W'(k);
      if (!found_s && req[cand_s]) begin
        found_s  = 1'b1;
        winner_s = cand_s;
      end else begin
        found_s  = found_s;
      end
    end
  end

  // Release causes while granted: explicit done, request withdrawn, hold limit.
  always_comb begin
    drop_s     = ~req[idx_q];
    early_s    = done | drop_s;
    hold_hit_s = HOLD_EN && (hold_q == HOLD_LAST);
    release_s  = early_s | hold_hit_s;
  end

  // Next-state logic for the IDLE/GRANT controller and its outputs.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    idx_d     = idx_q;
    valid_d   = valid_q;
    hold_d    = hold_q;
    timeout_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (found_s) begin
          state_d = ST_GRANT;
          idx_d   = winner_s;
          ptr_d   = winner_s;
          hold_d  = {HOLD_W{1'b0}};
          valid_d = 1'b1;
        end else begin
          valid_d = 1'b0;
        end
      end
      ST_GRANT: begin
        hold_d = hold_q + {{(HOLD_W-1){1'b0}}, 1'b1};
        if (release_s) begin
          state_d   = ST_IDLE;
          valid_d   = 1'b0;
          // Flag a timeout only when the limit alone ended the grant.
          timeout_d = hold_hit_s & ~early_s;
        end else begin
          valid_d   = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  // One-hot grant decoded from next-state index so gnt can be registered too.
  gnt_decode4to16 u_decode (
    .idx_i    (idx_d),
    .en_i     (valid_d),
    .onehot_o (gnt_d)
  );

  // State, pointer, counter and output registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      ptr_q     <= {IDX_W{1'b1}};
      idx_q     <= {IDX_W{1'b0}};
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      hold_q    <= {HOLD_W{1'b0}};
      gnt_q     <= {NUM_REQ{1'b0}};
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      idx_q     <= idx_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
      hold_q    <= hold_d;
      gnt_q     <= gnt_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_idx   = idx_q;
  assign gnt_valid = valid_q;
  assign timeout   = timeout_q;

endmodule : rr_arbiter16

// File: tb/tb_rr_arbiter16.sv
// Self-checking bench for rr_arbiter16: directed scenarios plus random traffic,
// checked every cycle against a behavioural round-robin model.
module tb_rr_arbiter16;

  localparam int MAXH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] req = 16'h0000;
  logic        done = 1'b0;
  logic [15:0] gnt;
  logic [3:0]  gnt_idx;
  logic        gnt_valid;
  logic        timeout;

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model state: active grant, grantee, last grantee, cycles held.
  logic        m_valid;
  logic [3:0]  m_idx;
  logic [3:0]  m_last;
  int          m_held;
  logic        m_to;

  rr_arbiter16 #(.MAX_HOLD(MAXH), .HOLD_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .done      (done),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  // Nearest requester after 'last' going upward modulo 16; 'last' itself is farthest.
  function automatic logic [3:0] rr_pick(input logic [15:0] r, input logic [3:0] last);
    int c;
    rr_pick = last;
    for (int j = 16; j >= 1; j--) begin
      c = (int'(last) + j) % 16;
      if (r[c]) rr_pick = 4'(c);
    end
  endfunction

  function automatic logic [15:0] exp_gnt();
    return m_valid ? (16'h0001 << m_idx) : 16'h0000;
  endfunction

  // Reference model advanced once per clock from the sampled inputs.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_idx   <= 4'd0;
      m_last  <= 4'd15;
      m_held  <= 0;
      m_to    <= 1'b0;
    end else begin
      m_to <= 1'b0;
      if (m_valid) begin
        if (done || !req[m_idx] || m_held == MAXH) begin
          m_valid <= 1'b0;
          m_to    <= !done && req[m_idx] && (m_held == MAXH);
        end else begin
          m_held <= m_held + 1;
        end
      end else if (req != 16'h0000) begin
        m_valid <= 1'b1;
        m_idx   <= rr_pick(req, m_last);
        m_last  <= rr_pick(req, m_last);
        m_held  <= 1;
      end
    end
  end

  // Cycle-by-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      n_cmp++;
      if ({gnt, gnt_idx, gnt_valid, timeout} !== {exp_gnt(), m_idx, m_valid, m_to}) begin
        n_bad++;
        $display("FAIL model t=%0t: got gnt=%h idx=%0d v=%b to=%b, expected gnt=%h idx=%0d v=%b to=%b",
                 $time, gnt, gnt_idx, gnt_valid, timeout, exp_gnt(), m_idx, m_valid, m_to);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = 16'h0000;
    done  = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    // Model arithmetic pinned by hand.
    chk("pick_skip", 32'(rr_pick(16'h0021, 4'd5)), 32'd0);
    chk("pick_wrap", 32'(rr_pick(16'h0003, 4'd15)), 32'd0);
    chk("pick_self", 32'(rr_pick(16'h0020, 4'd5)), 32'd5);

    // Reset values.
    step();
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_idx", 32'(gnt_idx), 32'd0);
    chk("rst_valid", 32'(gnt_valid), 32'd0);
    chk("rst_to", 32'(timeout), 32'd0);
    step();
    rst_n = 1'b1;

    // Single requester with done in cycle 3.
    req = 16'h0001;
    step(); chk("sr_c1_gnt", 32'(gnt), 32'h0001); chk("sr_c1_v", 32'(gnt_valid), 32'd1);
    step(); chk("sr_c2_gnt", 32'(gnt), 32'h0001);
    step(); chk("sr_c3_gnt", 32'(gnt), 32'h0001); done = 1'b1;
    step(); done = 1'b0; chk("sr_c4_v", 32'(gnt_valid), 32'd0); chk("sr_c4_gnt", 32'(gnt), 32'h0);
    step(); chk("sr_c5_v", 32'(gnt_valid), 32'd1); chk("sr_c5_idx", 32'(gnt_idx), 32'd0);

    // Asynchronous reset in the middle of a grant.
    #2 rst_n = 1'b0;
    #1;
    chk("arst_gnt", 32'(gnt), 32'h0);
    chk("arst_v", 32'(gnt_valid), 32'd0);
    chk("arst_to", 32'(timeout), 32'd0);
    req = 16'h0000;
    step();
    rst_n = 1'b1;
    req = 16'h0001;
    step(); chk("arst_regrant", 32'(gnt_idx), 32'd0); chk("arst_regrant_v", 32'(gnt_valid), 32'd1);

    // Full load with done held: 0..15 then wrap to 0, one dead cycle between grants.
    do_reset();
    req  = 16'hFFFF;
    done = 1'b1;
    for (int k = 0; k <= 16; k++) begin
      step(); chk($sformatf("full_idx%0d", k), 32'(gnt_idx), 32'(k % 16));
      chk($sformatf("full_v%0d", k), 32'(gnt_valid), 32'd1);
      step(); chk($sformatf("full_gap%0d", k), 32'(gnt_valid), 32'd0);
    end
    done = 1'b0;

    // Pointer skip: last grant 5, then requests 0 and 5 -> 0 wins.
    do_reset();
    req = 16'h0020;
    step(); chk("skip_first", 32'(gnt_idx), 32'd5);
    req = 16'h0021; done = 1'b1;
    step(); done = 1'b0; chk("skip_gap", 32'(gnt_valid), 32'd0);
    step(); chk("skip_next", 32'(gnt_idx), 32'd0);

    // Timeout: held 4 cycles, one-cycle timeout pulse, regrant of 8.
    do_reset();
    req = 16'h0100;
    for (int k = 1; k <= 4; k++) begin
      step(); chk($sformatf("to_hold%0d", k), 32'(gnt), 32'h0100); chk($sformatf("to_nopulse%0d", k), 32'(timeout), 32'd0);
    end
    step(); chk("to_v", 32'(gnt_valid), 32'd0); chk("to_pulse", 32'(timeout), 32'd1);
    step(); chk("to_regrant", 32'(gnt_idx), 32'd8); chk("to_pulse_end", 32'(timeout), 32'd0);

    // done on the 4th held cycle: release without timeout.
    do_reset();
    req = 16'h0100;
    step(); step(); step(); step();
    done = 1'b1;
    step(); done = 1'b0; chk("sim_done_v", 32'(gnt_valid), 32'd0); chk("sim_done_to", 32'(timeout), 32'd0);
    // Request drop on the 4th held cycle: release without timeout.
    step(); chk("sim_drop_gr", 32'(gnt_valid), 32'd1);
    step(); step(); step();
    req = 16'h0000;
    step(); chk("sim_drop_v", 32'(gnt_valid), 32'd0); chk("sim_drop_to", 32'(timeout), 32'd0);
    // done while idle changes nothing.
    done = 1'b1;
    step(); chk("idle_done_v", 32'(gnt_valid), 32'd0); chk("idle_done_idx", 32'(gnt_idx), 32'd8);
    step(); chk("idle_done_gnt", 32'(gnt), 32'h0);
    done = 1'b0;

    // Random traffic, with occasional resets.
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 7) == 0) begin
        case ($urandom_range(0, 3))
          0: req = 16'($urandom);
          1: req = 16'h0001 << $urandom_range(0, 15);
          2: req = 16'h0000;
          default: req = 16'hFFFF;
        endcase
      end
      done = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 499) == 0) begin
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
      end else begin
        step();
      end
    end
    done = 1'b0;
    req  = 16'h0000;
    step();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_rr_arbiter16
